mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ES_TO_MS_BUS_WD, default 123, width of the execute-to-memory bus.
REQ-002 Parameter MS_TO_WS_BUS_WD, default 70, width of the memory-to-writeback bus.
REQ-003 Port clk  input  1  clock; reset is synchronous, active-high, and named reset.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port ws_allowin  input  1  writeback stage can accept an instruction.
REQ-006 Port ms_allowin  output  1  this stage can accept an instruction.
REQ-007 Port es_to_ms_valid  input  1  execute stage offers an instruction.
REQ-008 Port es_to_ms_bus  input  ES_TO_MS_BUS_WD  instruction payload.
- [122:121] div_op
- [120:89] br_target
- [88:80] branch_op
- [79] Carry, [78] Sign, [77] Overflow, [76] Zero
- [75:71] load_op
- [70] mem_to_reg, [69] reg_we
- [68:64] dest
- [63:32] alu_result
- [31:0] pc
REQ-009 Port data_sram_rdata  input  32  load data, valid in the cycle after the address was issued.
REQ-010 Port div_quotient  input  32  divider quotient, valid at the cycle the divide leaves execute.
REQ-011 Port div_remainder  input  32  divider remainder, same timing as div_quotient.
REQ-012 Port ms_to_ws_valid  output  1  instruction offered to writeback.
REQ-013 Port ms_to_ws_bus  output  MS_TO_WS_BUS_WD  payload: {reg_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-014 Port ms_to_es_bus  output  32  final_result, forwarded to execute.
REQ-015 Port br_bus  output  33  {br_taken[32], br_target[31:0]}, sent to fetch.

Function
REQ-016 Valid register and input handshake:
- ms_ready_go = 1.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- On clk when ms_allowin: ms_valid <= es_to_ms_valid.
REQ-017 Payload capture and hold:
- When es_to_ms_valid && ms_allowin: capture es_to_ms_bus, div_quotient and div_remainder into internal registers.
- Otherwise those registers hold their value.
REQ-018 ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-019 Load data selection, using latched alu_result[1:0] as byte offset:
- ld.b (load_op[0]): sign-extend byte at offset.
- ld.h (load_op[1]): sign-extend halfword at offset[1]*16.
- ld.w (load_op[2]): full word.
- ld.bu (load_op[3]): zero-extend byte at offset.
- ld.hu (load_op[4]): zero-extend halfword at offset[1]*16.
- No bit set: 0.
REQ-020 final_result priority:
- mem_to_reg → load data.
- else div_op[0] → latched quotient.
- else div_op[1] → latched remainder.
- else alu_result.
REQ-021 Branch condition, from latched flags (Carry=1 means unsigned borrow):
- branch_op[0] beq: Zero.
- branch_op[1] bne: !Zero.
- branch_op[2] blt: Sign^Overflow.
- branch_op[3] bge: !(Sign^Overflow).
- branch_op[4] bltu: Carry.
- branch_op[5] bgeu: !Carry.
- branch_op[8:6] (b, bl, jirl): 1.
REQ-022 br_taken = ms_valid && OR of the enabled conditions.
REQ-023 br_target on br_bus is the latched br_target, passed through unchanged.
REQ-024 A stall (ws_allowin=0 with ms_valid=1):
- holds every output stable;
- keeps br_taken asserted;
- does not re-sample data_sram_rdata, which the upstream stage keeps valid by holding the address.
REQ-025 Back-to-back: a new instruction is accepted in the same cycle the current one is accepted by writeback, with no bubble.
REQ-026 Invalid slot: when ms_valid=0, ms_to_ws_valid=0 and br_taken=0 regardless of register contents.
REQ-027 Sub-word alignment: misaligned ld.h/ld.hu (offset 1 or 3) uses offset[1] only; no exception is raised.

Reset
REQ-028 On reset: ms_valid=0, payload and divider registers=0, ms_to_ws_valid=0, br_bus=0, ms_to_es_bus=0.
REQ-029 ms_allowin=1 in the first cycle after reset.
REQ-030 Reset asserted mid-operation discards the in-flight instruction, with no writeback and no branch.

Verification
REQ-031 ld.b, alu_result=0x1003, rdata=0x80FF1234 → final_result=0xFFFFFF80; ld.bu same inputs → 0x00000080.
REQ-032 ld.hu, alu_result=0x2002, rdata=0xBEEF0001 → 0x0000BEEF; ld.h same inputs → 0xFFFFBEEF.
REQ-033 bne with Zero=0, br_target=0x1C000040, valid → br_bus=0x1_1C000040; beq same flags → br_taken=0.
REQ-034 div_op=2'b10, remainder=7, quotient=3 captured, then execute changes the divider inputs → final_result stays 7.
REQ-035 ws_allowin=0 for 3 cycles with ms_valid=1 → ms_allowin=0 and outputs stable; release → one handoff, next instruction accepted the same cycle.
REQ-036 Reset asserted while ms_valid=1 → next cycle ms_to_ws_valid=0, br_bus=0, ms_allowin=1.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage.
// It latches the execute-stage payload and the divider results. It selects and
// extends load data from the data SRAM. It picks the final result for writeback
// and forwarding, and it resolves the branch condition from the latched flags.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   ws_allowin           writeback stage can accept an instruction
//   ms_allowin           this stage can accept an instruction
//   es_to_ms_valid/_bus  instruction offered by execute, with its payload
//   data_sram_rdata      load data (valid in the cycle after the address)
//   div_quotient/_remainder  divider results, captured with the instruction
//   ms_to_ws_valid/_bus  instruction offered to writeback {reg_we, dest, result, pc}
//   ms_to_es_bus         final result forwarded to execute
//   br_bus               {br_taken, br_target} sent to fetch
module mem_stage #(
  parameter int unsigned ES_TO_MS_BUS_WD = 123,
  parameter int unsigned MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic [31:0]                div_quotient,
  input  logic [31:0]                div_remainder,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [31:0]                ms_to_es_bus,
  output logic [32:0]                br_bus
);

  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic [31:0]                div_q_r;
  logic [31:0]                div_r_r;

  // Fields of the latched payload
  logic [1:0]  div_op;
  logic [31:0] br_target;
  logic [8:0]  branch_op;
  logic        flag_c;
  logic        flag_s;
  logic        flag_o;
  logic        flag_z;
  logic [4:0]  load_op;
  logic        mem_to_reg;
  logic        reg_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  logic [1:0]  ld_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] final_result;
  logic        signed_lt;
  logic        br_cond;
  logic        br_taken;

  // The stage never needs extra cycles: the load data arrives in the cycle the
  // instruction sits here.
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Valid flag and payload/divider capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      es_bus_r <= '0;
      div_q_r  <= '0;
      div_r_r  <= '0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        es_bus_r <= es_to_ms_bus;
        div_q_r  <= div_quotient;
        div_r_r  <= div_remainder;
      end
    end
  end

  assign div_op     = es_bus_r[122:121];
  assign br_target  = es_bus_r[120:89];
  assign branch_op  = es_bus_r[88:80];
  assign flag_c     = es_bus_r[79];
  assign flag_s     = es_bus_r[78];
  assign flag_o     = es_bus_r[77];
  assign flag_z     = es_bus_r[76];
  assign load_op    = es_bus_r[75:71];
  assign mem_to_reg = es_bus_r[70];
  assign reg_we     = es_bus_r[69];
  assign dest       = es_bus_r[68:64];
  assign alu_result = es_bus_r[63:32];
  assign pc         = es_bus_r[31:0];

  // Sub-word extraction; halfwords use only offset[1], so misaligned halves
  // silently round down.
  assign ld_off  = alu_result[1:0];
  assign ld_half = ld_off[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

  always_comb begin
    ld_byte = data_sram_rdata[7:0];
    case (ld_off)
      2'd1:    ld_byte = data_sram_rdata[15:8];
      2'd2:    ld_byte = data_sram_rdata[23:16];
      2'd3:    ld_byte = data_sram_rdata[31:24];
      default: ld_byte = data_sram_rdata[7:0];
    endcase
  end

  // Load-type extension
  always_comb begin
    ld_data = 32'h0;
    if (load_op[0]) begin
      ld_data = {{24{ld_byte[7]}}, ld_byte};
    end else if (load_op[1]) begin
      ld_data = {{16{ld_half[15]}}, ld_half};
    end else if (load_op[2]) begin
      ld_data = data_sram_rdata;
    end else if (load_op[3]) begin
      ld_data = {24'h0, ld_byte};
    end else if (load_op[4]) begin
      ld_data = {16'h0, ld_half};
    end
  end

  // Final result: load, then quotient, then remainder, then ALU
  always_comb begin
    final_result = alu_result;
    if (mem_to_reg) begin
      final_result = ld_data;
    end else if (div_op[0]) begin
      final_result = div_q_r;
    end else if (div_op[1]) begin
      final_result = div_r_r;
    end
  end

  // Branch resolution; Carry set means an unsigned borrow (a < b)
  assign signed_lt = flag_s ^ flag_o;
  assign br_cond   = (branch_op[0] &&  flag_z)
                  || (branch_op[1] && !flag_z)
                  || (branch_op[2] &&  signed_lt)
                  || (branch_op[3] && !signed_lt)
                  || (branch_op[4] &&  flag_c)
                  || (branch_op[5] && !flag_c)
                  || (|branch_op[8:6]);
  assign br_taken  = ms_valid && br_cond;

  assign br_bus       = {br_taken, br_target};
  assign ms_to_es_bus = final_result;
  assign ms_to_ws_bus = MS_TO_WS_BUS_WD'({reg_we, dest, final_result, pc});

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and scoreboard checks for mem_stage.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [122:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic [31:0]  div_quotient;
  logic [31:0]  div_remainder;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [31:0]  ms_to_es_bus;
  logic [32:0]  br_bus;

  mem_stage #(.ES_TO_MS_BUS_WD(123), .MS_TO_WS_BUS_WD(70)) dut (
    .clk            (clk),
    .reset          (reset),
    .ws_allowin     (ws_allowin),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .data_sram_rdata(data_sram_rdata),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ms_to_es_bus   (ms_to_es_bus),
    .br_bus         (br_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  div_op;
    logic [31:0] target;
    logic [8:0]  bop;
    logic [3:0]  flags;   // {C, S, O, Z}
    logic [4:0]  lop;
    logic        m2r;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic        exp_tk;
  } vec_t;

  typedef struct {
    logic [69:0] ws_bus;
    logic [32:0] br;
    logic [31:0] es;
  } exp_t;

  localparam int unsigned NVEC = 19;

  vec_t tbl [NVEC];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] div_op, input logic [8:0] bop,
                              input logic [3:0] flags, input logic [4:0] lop,
                              input logic m2r, input logic [31:0] alu,
                              input logic [31:0] rdata, input logic [31:0] quot,
                              input logic [31:0] rem, input logic [31:0] target,
                              input logic [31:0] exp_res, input logic exp_tk);
    vec_t v;
    v.div_op = div_op;  v.bop = bop;     v.flags = flags;   v.lop = lop;
    v.m2r = m2r;        v.alu = alu;     v.rdata = rdata;   v.quot = quot;
    v.rem = rem;        v.target = target;
    v.exp_res = exp_res; v.exp_tk = exp_tk;
    v.we = 1'b1;        v.dest = 5'd1;   v.pc = 32'h1C00_0000;
    return v;
  endfunction

  function automatic logic [122:0] make_bus(input vec_t v);
    return {v.div_op, v.target, v.bop, v.flags, v.lop, v.m2r, v.we, v.dest, v.alu, v.pc};
  endfunction

  function automatic exp_t make_exp(input vec_t v);
    exp_t e;
    e.ws_bus = {v.we, v.dest, v.exp_res, v.pc};
    e.br     = {v.exp_tk, v.target};
    e.es     = v.exp_res;
    return e;
  endfunction

  task automatic offer(input vec_t v);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = make_bus(v);
    div_quotient   = v.quot;
    div_remainder  = v.rem;
  endtask

  task automatic push(input vec_t v);
    exp_q.push_back(make_exp(v));
    pushed++;
  endtask

  // Scoreboard: compare every instruction handed to writeback
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handoff got bus %h expected none", ms_to_ws_bus);
      end else begin
        e = exp_q.pop_front();
        popped++;
        chk("ws_bus", 70'(ms_to_ws_bus), e.ws_bus);
        chk("br_bus", 70'(br_bus), 70'(e.br));
        chk("es_bus", 70'(ms_to_es_bus), 70'(e.es));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t s;
    vec_t t;
    vec_t r;

    //            div    bop      flags    lop       m2r  alu           rdata         quot   rem    target        result        tk
    tbl[0]  = mk(2'b00, 9'h000, 4'b0000, 5'b00001, 1'b1, 32'h0000_1003, 32'h80FF_1234, 32'h11, 32'h22, 32'h0,         32'hFFFF_FF80, 1'b0);
    tbl[1]  = mk(2'b00, 9'h000, 4'b0000, 5'b01000, 1'b1, 32'h0000_1003, 32'h80FF_1234, 32'h11, 32'h22, 32'h0,         32'h0000_0080, 1'b0);
    tbl[2]  = mk(2'b00, 9'h000, 4'b0000, 5'b10000, 1'b1, 32'h0000_2002, 32'hBEEF_0001, 32'h11, 32'h22, 32'h0,         32'h0000_BEEF, 1'b0);
    tbl[3]  = mk(2'b00, 9'h000, 4'b0000, 5'b00010, 1'b1, 32'h0000_2002, 32'hBEEF_0001, 32'h11, 32'h22, 32'h0,         32'hFFFF_BEEF, 1'b0);
    tbl[4]  = mk(2'b00, 9'h000, 4'b0000, 5'b00100, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 32'h11, 32'h22, 32'h0,         32'hDEAD_BEEF, 1'b0);
    tbl[5]  = mk(2'b00, 9'h000, 4'b0000, 5'b00010, 1'b1, 32'h0000_3001, 32'h1234_8765, 32'h11, 32'h22, 32'h0,         32'hFFFF_8765, 1'b0);
    tbl[6]  = mk(2'b00, 9'h000, 4'b0000, 5'b10000, 1'b1, 32'h0000_3003, 32'h8765_1234, 32'h11, 32'h22, 32'h0,         32'h0000_8765, 1'b0);
    tbl[7]  = mk(2'b00, 9'h000, 4'b0000, 5'b01000, 1'b1, 32'h0000_4001, 32'h1234_8765, 32'h11, 32'h22, 32'h0,         32'h0000_0087, 1'b0);
    tbl[8]  = mk(2'b00, 9'h002, 4'b0000, 5'b00000, 1'b0, 32'h0000_0055, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_0040, 32'h0000_0055, 1'b1);
    tbl[9]  = mk(2'b00, 9'h001, 4'b0000, 5'b00000, 1'b0, 32'h0000_0055, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_0040, 32'h0000_0055, 1'b0);
    tbl[10] = mk(2'b00, 9'h004, 4'b0100, 5'b00000, 1'b0, 32'h0000_0056, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_0044, 32'h0000_0056, 1'b1);
    tbl[11] = mk(2'b00, 9'h008, 4'b0110, 5'b00000, 1'b0, 32'h0000_0057, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_0048, 32'h0000_0057, 1'b1);
    tbl[12] = mk(2'b00, 9'h010, 4'b0000, 5'b00000, 1'b0, 32'h0000_0058, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_004C, 32'h0000_0058, 1'b0);
    tbl[13] = mk(2'b00, 9'h020, 4'b0000, 5'b00000, 1'b0, 32'h0000_0059, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_0050, 32'h0000_0059, 1'b1);
    tbl[14] = mk(2'b00, 9'h100, 4'b0000, 5'b00000, 1'b0, 32'h0000_005A, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_0054, 32'h0000_005A, 1'b1);
    tbl[15] = mk(2'b01, 9'h000, 4'b0000, 5'b00000, 1'b0, 32'h0000_0099, 32'hFFFF_FFFF, 32'h3,  32'h7,  32'h0,         32'h0000_0003, 1'b0);
    tbl[16] = mk(2'b10, 9'h000, 4'b0000, 5'b00000, 1'b0, 32'h0000_0099, 32'hFFFF_FFFF, 32'h3,  32'h7,  32'h0,         32'h0000_0007, 1'b0);
    tbl[17] = mk(2'b01, 9'h000, 4'b0000, 5'b00000, 1'b1, 32'h0000_0077, 32'hFFFF_FFFF, 32'h3,  32'h7,  32'h0,         32'h0000_0000, 1'b0);
    tbl[18] = mk(2'b00, 9'h011, 4'b1001, 5'b00000, 1'b0, 32'h0000_0078, 32'hFFFF_FFFF, 32'h11, 32'h22, 32'h1C00_0058, 32'h0000_0078, 1'b1);
    for (int i = 0; i < int'(NVEC); i++) begin
      tbl[i].dest = 5'(i);
      tbl[i].we   = 1'(i % 2);
      tbl[i].pc   = 32'h1C00_0000 + 32'(i * 4);
    end

    // Reset and first cycle after it
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_rdata = '0; div_quotient = '0; div_remainder = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 70'(ms_allowin), 70'(1));
    chk("rst_ws_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rst_br_bus", 70'(br_bus), 70'(0));
    chk("rst_es_bus", 70'(ms_to_es_bus), 70'(0));
    @(posedge clk); #1;

    // Back-to-back vectors; each load's rdata follows one cycle after its offer
    for (int i = 0; i <= int'(NVEC); i++) begin
      if (i < int'(NVEC)) begin
        offer(tbl[i]);
        push(tbl[i]);
      end else begin
        es_to_ms_valid = 1'b0;
      end
      if (i > 0) data_sram_rdata = tbl[i-1].rdata;
      @(posedge clk); #1;
    end

    // Stall with a held remainder and a taken branch, then release
    s = mk(2'b10, 9'h040, 4'b0000, 5'b00000, 1'b0, 32'h0000_1234, 32'h0, 32'h3, 32'h7,
           32'h1C00_0080, 32'h0000_0007, 1'b1);
    s.dest = 5'd9; s.pc = 32'h1C00_0100;
    t = mk(2'b00, 9'h080, 4'b0000, 5'b00000, 1'b0, 32'h0000_CAFE, 32'h0, 32'h0, 32'h0,
           32'h1C00_00C0, 32'h0000_CAFE, 1'b1);
    t.dest = 5'd10; t.pc = 32'h1C00_0104;
    offer(s);
    push(s);
    @(posedge clk); #1;
    ws_allowin = 1'b0;
    offer(t);
    for (int c = 0; c < 3; c++) begin
      div_quotient  = 32'hAAAA_0000 + 32'(c);
      div_remainder = 32'hBBBB_0000 + 32'(c);
      @(negedge clk);
      chk("stall_allowin", 70'(ms_allowin), 70'(0));
      chk("stall_ws_valid", 70'(ms_to_ws_valid), 70'(1));
      chk("stall_br_bus", 70'(br_bus), 70'({1'b1, 32'h1C00_0080}));
      chk("stall_ws_bus", 70'(ms_to_ws_bus), {1'b1, 5'd9, 32'h7, 32'h1C00_0100});
      @(posedge clk); #1;
    end
    ws_allowin = 1'b1;
    push(t);
    @(negedge clk);
    chk("release_allowin", 70'(ms_allowin), 70'(1));
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("next_accepted", 70'(ms_to_ws_valid), 70'(1));
    @(posedge clk); #1;
    // Slot now empty while the payload register still holds a taken branch
    @(negedge clk);
    chk("empty_ws_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("empty_br_taken", 70'(br_bus[32]), 70'(0));
    @(posedge clk); #1;

    // Reset discards an in-flight taken branch
    r = mk(2'b00, 9'h080, 4'b0000, 5'b00000, 1'b0, 32'h0000_0042, 32'h0, 32'h0, 32'h0,
           32'h1C00_0200, 32'h0000_0042, 1'b1);
    ws_allowin = 1'b0;
    offer(r);
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("inflight_br_taken", 70'(br_bus[32]), 70'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ws_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("midrst_br_bus", 70'(br_bus), 70'(0));
    chk("midrst_allowin", 70'(ms_allowin), 70'(1));
    chk("midrst_es_bus", 70'(ms_to_es_bus), 70'(0));
    ws_allowin = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("scoreboard_drained", 70'(popped), 70'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
